// File: rtl/multistep_shifter.sv
// Iterative shifter: moves up to STEP positions per clock for logical, arithmetic and rotate ops.
// Optional sticky output (OR of discarded bits) enabled by defining MULTISTEP_SHIFTER_STICKY_EN.
module multistep_shifter #(
    parameter  int N    = 8,
    parameter  int STEP = 2,
    localparam int W    = $clog2(N) + 1
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic         i_direction,
    input  logic [1:0]   i_mode,
    input  logic [N-1:0] i_amount,
    input  logic [N-1:0] i_value,
    output logic         o_busy,
    output logic         o_finished,
    output logic [N-1:0] o_result,
    output logic         o_sticky
);
    localparam int           LOG2N  = $clog2(N);
    localparam logic [W-1:0] STEP_W = W'(STEP);
    localparam logic [W-1:0] N_W    = W'(N);
    localparam logic [N-1:0] N_AMT  = N'(N);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t       state, state_next;
    logic [N-1:0] work, shift_next;
    logic         dir_q;
    logic [1:0]   mode_q;
    logic [W-1:0] rem, eff_amt, k, inv_k;
    logic         accept, last;

    always_comb begin
        accept = i_start && (state != SHIFT);
        if (i_mode == 2'b10)
            eff_amt = W'(i_amount[LOG2N-1:0]);
        else if (i_amount >= N_AMT)
            eff_amt = N_W;
        else
            eff_amt = i_amount[W-1:0];
        k     = (rem > STEP_W) ? STEP_W : rem;
        inv_k = N_W - k;
        last  = (rem == k);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) state_next = (eff_amt == '0) ? DONE : SHIFT;
                else        state_next = IDLE;
            end
            SHIFT:      if (last) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Rotate never moves N or more positions, so inv_k stays in 1..N-1 there.
    always_comb begin
        shift_next = work;
        unique case (mode_q)
            2'b10:   shift_next = dir_q ? ((work << k) | (work >> inv_k))
                                        : ((work >> k) | (work << inv_k));
            2'b01:   shift_next = dir_q ? (work << k) : N'($signed(work) >>> k);
            default: shift_next = dir_q ? (work << k) : (work >> k);
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            work     <= '0;
            dir_q    <= 1'b0;
            mode_q   <= 2'b00;
            rem      <= '0;
            o_result <= '0;
        end else if (accept) begin
            work   <= i_value;
            dir_q  <= i_direction;
            mode_q <= i_mode;
            rem    <= eff_amt;
            if (eff_amt == '0) o_result <= i_value;
        end else if (state == SHIFT) begin
            work <= shift_next;
            rem  <= rem - k;
            if (last) o_result <= shift_next;
        end
    end

    assign o_busy     = (state == SHIFT);
    assign o_finished = (state == DONE);

`ifdef MULTISTEP_SHIFTER_STICKY_EN
    logic [N:0] low_mask;
    logic       step_out, sticky_acc;

    // Bits leaving this step: top k bits when going left, bottom k when going right.
    always_comb begin
        low_mask = ((N+1)'(1) << k) - (N+1)'(1);
        if (mode_q == 2'b10) step_out = 1'b0;
        else if (dir_q)      step_out = |(work >> inv_k);
        else                 step_out = |(work & low_mask[N-1:0]);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || accept) begin
            sticky_acc <= 1'b0;
            o_sticky   <= 1'b0;
        end else if (state == SHIFT) begin
            sticky_acc <= sticky_acc | step_out;
            if (last) o_sticky <= sticky_acc | step_out;
        end
    end
`else
    assign o_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_multistep_shifter.sv
// Self-checking bench for multistep_shifter: directed table, corner sequences, random vs bit-serial model.
module tb_multistep_shifter;
    localparam int N    = 8;
    localparam int STEP = 2;
`ifdef MULTISTEP_SHIFTER_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start, dir;
    logic [1:0]   mode;
    logic [N-1:0] amt, val;
    logic         busy, fin, sticky;
    logic [N-1:0] res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multistep_shifter #(.N(N), .STEP(STEP)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_direction(dir),
        .i_mode(mode), .i_amount(amt), .i_value(val),
        .o_busy(busy), .o_finished(fin), .o_result(res), .o_sticky(sticky)
    );

    typedef struct {
        logic         d;
        logic [1:0]   m;
        logic [N-1:0] a;
        logic [N-1:0] v;
        logic [N-1:0] r;
        logic         s;
        int           lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic d, input logic [1:0] m, input logic [N-1:0] a, input logic [N-1:0] v);
        dir = d; mode = m; amt = a; val = v; start = 1'b1;
    endtask

    // Called while start is driven; returns at the negedge of the finished cycle.
    task automatic wait_done(input string name, input logic [N-1:0] er, input logic es,
                             input int el, input int glitch);
        int cyc;
        bit busy_ok = 1'b1;
        bit seen    = 1'b0;
        @(posedge clk);
        cyc = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cyc == glitch) begin
                start = 1'b1; val = ~val; amt = 1; dir = ~dir;
            end else begin
                start = 1'b0;
            end
            if (fin) begin
                seen = 1'b1;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            cyc++;
        end
        chk({name, " finished_seen"}, 32'(seen), 32'd1);
        chk({name, " latency"}, 32'(cyc), 32'(el));
        chk({name, " busy_while_shift"}, 32'(busy_ok), 32'd1);
        chk({name, " busy_at_done"}, 32'(busy), 32'd0);
        chk({name, " result"}, 32'(res), 32'(er));
        chk({name, " sticky"}, 32'(sticky), 32'(es & STK));
    endtask

    // Reference: one bit position per iteration, E times.
    function automatic void model(input logic d, input logic [1:0] m, input logic [N-1:0] a,
                                  input logic [N-1:0] v, output logic [N-1:0] r,
                                  output logic s, output int lat);
        int e;
        r = v;
        s = 1'b0;
        if (m == 2'b10) e = int'(a) % N;
        else            e = (int'(a) >= N) ? N : int'(a);
        for (int i = 0; i < e; i++) begin
            if (m == 2'b10) begin
                r = d ? {r[N-2:0], r[N-1]} : {r[0], r[N-1:1]};
            end else if (d) begin
                s = s | r[N-1];
                r = {r[N-2:0], 1'b0};
            end else begin
                s = s | r[0];
                r = (m == 2'b01) ? {r[N-1], r[N-1:1]} : {1'b0, r[N-1:1]};
            end
        end
        lat = (e + STEP - 1) / STEP + 1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] hold, er, ra, rv;
        logic         es, rd;
        logic [1:0]   rm;
        int           el;
        bit           seen_fin;

        vecs[0]  = '{1'b1, 2'b00, 8'd3,   8'h96, 8'hB0, 1'b1, 3};
        vecs[1]  = '{1'b0, 2'b01, 8'd3,   8'h96, 8'hF2, 1'b1, 3};
        vecs[2]  = '{1'b0, 2'b01, 8'd200, 8'h96, 8'hFF, 1'b1, 5};
        vecs[3]  = '{1'b0, 2'b00, 8'd200, 8'h96, 8'h00, 1'b1, 5};
        vecs[4]  = '{1'b1, 2'b10, 8'd11,  8'h96, 8'hB4, 1'b0, 3};
        vecs[5]  = '{1'b0, 2'b10, 8'd8,   8'h96, 8'h96, 1'b0, 1};
        vecs[6]  = '{1'b1, 2'b00, 8'd0,   8'h5A, 8'h5A, 1'b0, 1};
        vecs[7]  = '{1'b0, 2'b00, 8'd2,   8'h96, 8'h25, 1'b1, 2};
        vecs[8]  = '{1'b0, 2'b00, 8'd1,   8'h96, 8'h4B, 1'b0, 2};
        vecs[9]  = '{1'b0, 2'b10, 8'd3,   8'h96, 8'hD2, 1'b0, 3};
        vecs[10] = '{1'b1, 2'b11, 8'd3,   8'h96, 8'hB0, 1'b1, 3};
        vecs[11] = '{1'b1, 2'b01, 8'd3,   8'h96, 8'hB0, 1'b1, 3};

        rst = 1'b1; start = 1'b0; dir = 1'b0; mode = 2'b00; amt = '0; val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset finished", 32'(fin), 32'd0);
        chk("reset result", 32'(res), 32'd0);
        chk("reset sticky", 32'(sticky), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            launch(vecs[i].d, vecs[i].m, vecs[i].a, vecs[i].v);
            wait_done($sformatf("vec%0d", i), vecs[i].r, vecs[i].s, vecs[i].lat, 0);
            hold = res;
            @(negedge clk);
            chk($sformatf("vec%0d pulse_one_cycle", i), 32'(fin), 32'd0);
            chk($sformatf("vec%0d result_held", i), 32'(res), 32'(hold));
        end

        // Back-to-back: second start during the DONE cycle of the first.
        @(negedge clk);
        launch(1'b1, 2'b00, 8'd3, 8'h96);
        wait_done("b2b_first", 8'hB0, 1'b1, 3, 0);
        launch(1'b0, 2'b01, 8'd3, 8'h96);
        wait_done("b2b_second", 8'hF2, 1'b1, 3, 0);

        // Start pulse with altered inputs in the middle of SHIFT must be ignored.
        @(negedge clk);
        launch(1'b1, 2'b00, 8'd6, 8'h96);
        wait_done("mid_start_ignored", 8'h80, 1'b1, 4, 2);

        // Reset during cycle t+2 of a 4-cycle operation.
        @(negedge clk);
        launch(1'b1, 2'b00, 8'd6, 8'h96);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort finished", 32'(fin), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort result", 32'(res), 32'd0);
        chk("abort sticky", 32'(sticky), 32'd0);
        rst = 1'b0;
        launch(1'b0, 2'b00, 8'd1, 8'h96);
        wait_done("after_abort", 8'h4B, 1'b0, 2, 0);

        // Reset and start together: start is dropped.
        @(negedge clk);
        rst = 1'b1;
        launch(1'b1, 2'b00, 8'd3, 8'h96);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        seen_fin = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (fin || busy) seen_fin = 1'b1;
        end
        chk("reset_beats_start", 32'(seen_fin), 32'd0);

        for (int i = 0; i < 150; i++) begin
            rd = 1'($urandom);
            rm = 2'($urandom);
            ra = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
            rv = 8'($urandom);
            model(rd, rm, ra, rv, er, es, el);
            @(negedge clk);
            launch(rd, rm, ra, rv);
            wait_done($sformatf("rand%0d d=%0d m=%0d a=%0d v=%0h", i, rd, rm, ra, rv), er, es, el, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
